// File: rtl/sara_seg_carry_seq_if.sv
// Valid/ready bundle for the segmented carry stage: operand side plus result side.
// With SARA_ERR_FLAG_EN defined the bundle also carries the speculation error flag and counter.
interface sara_seg_carry_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             approx;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SARA_ERR_FLAG_EN
    logic             err;
    logic [7:0]       err_cnt;
`endif

    modport master (
        output in_valid, a, b, cin, approx, out_ready,
`ifdef SARA_ERR_FLAG_EN
        input  err, err_cnt,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, approx, out_ready,
`ifdef SARA_ERR_FLAG_EN
        output err, err_cnt,
`endif
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/sara_seg_carry_seq.sv
// Segmented adder stage: exact mode ripples one SEG-bit segment per cycle, SARA mode resolves
// all segments in one cycle from speculated carry-ins. Optional SARA_ERR_FLAG_EN adds err/err_cnt.
module sara_seg_carry_seq #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    sara_seg_carry_seq_if.slave bus
);
    // WIDTH must be a multiple of SEG with at least two segments.
    localparam int NSEG  = WIDTH / SEG;
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN_EXACT  = 2'd1,
        RUN_APPROX = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             in_ready_q;
    logic             out_valid;
    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] p_w;
    logic [WIDTH-1:0] g_w;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] apx_sum;
    logic             apx_cout;
    logic             c_q;
    logic             cout_q;
    logic [IDX_W-1:0] seg_idx;
    logic [SEG:0]     ex_res;
`ifdef SARA_ERR_FLAG_EN
    logic             apx_err;
    logic             err_q;
    logic [7:0]       err_cnt_q;
`endif

    // Exact ripple through one segment; returns {carry_out, sum_bits}.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] p,
                                              input logic [SEG-1:0] g,
                                              input logic           ci);
        logic [SEG-1:0] s;
        logic           c;
        c = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        return {c, s};
    endfunction

`ifdef SARA_ERR_FLAG_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    assign accept    = (state_q == IDLE) & in_ready_q & bus.in_valid;
    assign handshake = out_valid & bus.out_ready;

    assign p_w = a_p0 ^ b_p0;
    assign g_w = a_p0 & b_p0;

    assign ex_res = seg_add(p_w[seg_idx*SEG +: SEG], g_w[seg_idx*SEG +: SEG], c_q);

    // Speculative resolve: segment k>0 takes the previous segment's MSB generate as carry-in.
    always_comb begin
        logic [SEG:0] r;
        logic         spec_ci;
`ifdef SARA_ERR_FLAG_EN
        logic [SEG:0] t;
        logic         true_ci;
`endif
        apx_sum = '0;
        r = seg_add(p_w[SEG-1:0], g_w[SEG-1:0], c_q);
        apx_sum[SEG-1:0] = r[SEG-1:0];
        apx_cout = r[SEG];
`ifdef SARA_ERR_FLAG_EN
        apx_err = 1'b0;
        true_ci = r[SEG];
`endif
        for (int k = 1; k < NSEG; k++) begin
            spec_ci = g_w[k*SEG-1];
            r = seg_add(p_w[k*SEG +: SEG], g_w[k*SEG +: SEG], spec_ci);
            apx_sum[k*SEG +: SEG] = r[SEG-1:0];
            apx_cout = r[SEG];
`ifdef SARA_ERR_FLAG_EN
            if (spec_ci != true_ci) apx_err = 1'b1;
            t = seg_add(p_w[k*SEG +: SEG], g_w[k*SEG +: SEG], true_ci);
            true_ci = t[SEG];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = bus.approx ? RUN_APPROX : RUN_EXACT;
            end
            RUN_EXACT: begin
                if (seg_idx == LAST_IDX) state_d = DONE;
            end
            RUN_APPROX: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: operand capture at accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= bus.a;
            b_p0 <= bus.b;
        end
    end

    // Stage p1: carry resolution into the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= 1'b0;
            seg_idx <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SARA_ERR_FLAG_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                c_q     <= bus.cin;
                seg_idx <= '0;
            end else if (state_q == RUN_EXACT) begin
                sum_q[seg_idx*SEG +: SEG] <= ex_res[SEG-1:0];
                c_q                       <= ex_res[SEG];
                if (seg_idx == LAST_IDX) begin
                    seg_idx <= '0;
                    cout_q  <= ex_res[SEG];
`ifdef SARA_ERR_FLAG_EN
                    err_q   <= 1'b0;
`endif
                end else begin
                    seg_idx <= seg_idx + 1'b1;
                end
            end else if (state_q == RUN_APPROX) begin
                sum_q  <= apx_sum;
                cout_q <= apx_cout;
`ifdef SARA_ERR_FLAG_EN
                err_q  <= apx_err;
`endif
            end
        end
    end

`ifdef SARA_ERR_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (handshake && err_q) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
        end
    end

    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_sara_seg_carry_seq.sv
// Bench for sara_seg_carry_seq: directed vector table, hand sequences for backpressure and
// mid-operation reset, then random operations against an arithmetic reference model.
module tb_sara_seg_carry_seq;
    localparam int W  = 16;
    localparam int S  = 4;
    localparam int NS = W / S;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sara_seg_carry_seq_if #(.WIDTH(W)) bus();

    sara_seg_carry_seq #(.WIDTH(W), .SEG(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int exp_err_cnt = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         approx;
        logic [W-1:0] s;
        logic         co;
        int           lat;
        logic         e;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference: exact is plain addition; SARA adds each segment on its own with the
    // previous segment's top-bit generate as carry-in, true carry from the low-order sum.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic approx,
                                  output logic [W-1:0] s, output logic co, output logic e);
        int   t, tc, lo, mask;
        logic ci;
        s  = '0;
        co = 1'b0;
        e  = 1'b0;
        if (!approx) begin
            t  = int'(a) + int'(b) + int'(cin);
            s  = t[W-1:0];
            co = t[W];
        end else begin
            for (int k = 0; k < NS; k++) begin
                lo   = k * S;
                ci   = (k == 0) ? cin : (a[lo-1] & b[lo-1]);
                t    = ((int'(a) >> lo) & ((1 << S) - 1)) + ((int'(b) >> lo) & ((1 << S) - 1)) + int'(ci);
                mask = (1 << lo) - 1;
                tc   = ((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> lo;
                if (k > 0 && tc[0] != ci) e = 1'b1;
                s[lo +: S] = t[S-1:0];
                co = t[S];
            end
        end
    endfunction

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic approx, input int backp,
                         input logic early_ready, input logic [W-1:0] es, input logic ec,
                         input int elat, input logic ee);
        int waitc;
        int lat;
        waitc = 0;
        while (!bus.in_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, " in_ready_pre"}, bus.in_ready, 1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.approx   = approx;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'($urandom);
        bus.approx   = ~approx;
        if (early_ready) bus.out_ready = 1'b1;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, elat);
        check({tag, " sum"}, bus.sum, es);
        check({tag, " cout"}, bus.cout, ec);
`ifdef SARA_ERR_FLAG_EN
        check({tag, " err"}, bus.err, ee);
`endif
        for (int i = 0; i < backp; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = W'($urandom);
            bus.approx   = 1'($urandom);
            @(posedge clk); #1;
            check({tag, " hold out_valid"}, bus.out_valid, 1);
            check({tag, " hold in_ready"}, bus.in_ready, 0);
            check({tag, " hold sum"}, bus.sum, es);
            check({tag, " hold cout"}, bus.cout, ec);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (ee && exp_err_cnt < 255) exp_err_cnt++;
        check({tag, " post out_valid"}, bus.out_valid, 0);
        check({tag, " post in_ready"}, bus.in_ready, 1);
`ifdef SARA_ERR_FLAG_EN
        check({tag, " err_cnt"}, bus.err_cnt, exp_err_cnt);
`endif
    endtask

    initial begin
        logic [W-1:0] ra, rb, ms;
        logic         rc, rx, mc, me, er;
        int           bp;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 4, 1'b0};
        tbl[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00F0, 1'b0, 1, 1'b1};
        tbl[2] = '{16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0010, 1'b0, 1, 1'b0};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4, 1'b0};
        tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFF0, 1'b0, 1, 1'b1};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 4, 1'b0};
        tbl[6] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'hFFF0, 1'b0, 1, 1'b1};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.approx    = 1'b0;
        bus.out_ready = 1'b0;

        #1 rst_n = 1'b0;
        #11;
        check("reset in_ready", bus.in_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset sum", bus.sum, 0);
        check("reset cout", bus.cout, 0);
`ifdef SARA_ERR_FLAG_EN
        check("reset err", bus.err, 0);
        check("reset err_cnt", bus.err_cnt, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle in_ready", bus.in_ready, 1);

        // out_ready with nothing pending must not disturb IDLE.
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle out_ready out_valid", bus.out_valid, 0);
        check("idle out_ready in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].approx,
                  0, 1'b0, tbl[i].s, tbl[i].co, tbl[i].lat, tbl[i].e);
        end

        do_op("backpressure", 16'h00FF, 16'h0001, 1'b0, 1'b0, 3, 1'b0, 16'h0100, 1'b0, 4, 1'b0);

        // Abort an exact operation after its first segment has been written.
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.approx = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_err_cnt = 0;
        #1;
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst sum", bus.sum, 0);
        check("midrst cout", bus.cout, 0);
        check("midrst in_ready", bus.in_ready, 0);
`ifdef SARA_ERR_FLAG_EN
        check("midrst err_cnt", bus.err_cnt, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst release in_ready", bus.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst no out_valid", bus.out_valid, 0);
        end
        do_op("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 0, 1'b0, 16'h3333, 1'b0, 4, 1'b0);

        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rx = 1'($urandom);
            bp = $urandom_range(0, 2);
            er = (bp == 0) && ($urandom_range(0, 1) == 1);
            model(ra, rb, rc, rx, ms, mc, me);
            do_op($sformatf("rand%0d", n), ra, rb, rc, rx, bp, er, ms, mc, rx ? 1 : NS, me);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
